// File: rtl/card_match_controller.sv
// Two-player memory-card game sequencer for a 4x4 board: owns card state, cursor,
// turn, scores and the reveal/turn timers that pace each move.
module card_match_controller #(
    parameter int N_CARDS     = 16,
    parameter int SHOW_CYCLES = 50_000_000,
    parameter int TURN_CYCLES = 750_000_000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   btn_next,
    input  logic                   btn_sel,
    input  logic [3*N_CARDS-1:0]   deck_sym,
    output logic [3*N_CARDS-1:0]   card_sym,
    output logic [3:0]             cursor,
    output logic [N_CARDS-1:0]     face_up,
    output logic [N_CARDS-1:0]     matched,
    output logic                   player,
    output logic [3:0]             score0,
    output logic [3:0]             score1,
    output logic                   game_over,
    output logic [1:0]             winner,
    output logic [2:0]             state
);
    localparam int TW = $clog2(TURN_CYCLES + 1);
    localparam int SW = $clog2(SHOW_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PICK1   = 3'd1,
        S_PICK2   = 3'd2,
        S_SHOW    = 3'd3,
        S_RESOLVE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t               r_state;
    logic [3*N_CARDS-1:0] r_card_sym;
    logic [3:0]           r_cursor, r_pick_a, r_pick_b;
    logic [N_CARDS-1:0]   r_face_up, r_matched;
    logic                 r_player, r_game_over;
    logic [3:0]           r_score0, r_score1;
    logic [1:0]           r_winner;
    logic [TW-1:0]        r_turn_cnt;
    logic [SW-1:0]        r_show_cnt;

    logic [2:0]           w_syms [N_CARDS];
    logic                 w_sel_ok, w_timeout, w_match, w_done;
    logic [N_CARDS-1:0]   w_cur_mask, w_pair_mask;
    logic [3:0]           w_s0_nxt, w_s1_nxt;
    logic [4:0]           w_sum;

    for (genvar g = 0; g < N_CARDS; g++) begin : g_sym
        assign w_syms[g] = r_card_sym[3*g +: 3];
    end

    assign w_cur_mask  = N_CARDS'(1) << r_cursor;
    assign w_pair_mask = (N_CARDS'(1) << r_pick_a) | (N_CARDS'(1) << r_pick_b);
    assign w_sel_ok    = btn_sel && !r_face_up[r_cursor] && !r_matched[r_cursor];
    assign w_timeout   = (r_turn_cnt == TW'(TURN_CYCLES - 1));
    assign w_match     = (w_syms[r_pick_a] == w_syms[r_pick_b]);
    // Scores saturate at 8 so a malformed deck can never wrap them.
    assign w_s0_nxt    = (w_match && !r_player && r_score0 < 4'd8) ? r_score0 + 4'd1 : r_score0;
    assign w_s1_nxt    = (w_match &&  r_player && r_score1 < 4'd8) ? r_score1 + 4'd1 : r_score1;
    assign w_sum       = {1'b0, w_s0_nxt} + {1'b0, w_s1_nxt};
    assign w_done      = (w_sum == 5'd8);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_card_sym  <= '0;
            r_cursor    <= '0;
            r_pick_a    <= '0;
            r_pick_b    <= '0;
            r_face_up   <= '0;
            r_matched   <= '0;
            r_player    <= 1'b0;
            r_game_over <= 1'b0;
            r_score0    <= '0;
            r_score1    <= '0;
            r_winner    <= '0;
            r_turn_cnt  <= '0;
            r_show_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_card_sym  <= deck_sym;
                        r_face_up   <= '0;
                        r_matched   <= '0;
                        r_score0    <= '0;
                        r_score1    <= '0;
                        r_cursor    <= '0;
                        r_player    <= 1'b0;
                        r_winner    <= '0;
                        r_game_over <= 1'b0;
                        r_turn_cnt  <= '0;
                        r_state     <= S_PICK1;
                    end
                end
                S_PICK1, S_PICK2: begin
                    if (btn_next)
                        r_cursor <= r_cursor + 4'd1;
                    // Timeout beats a same-cycle select; face-up cards are never matched ones.
                    if (w_timeout) begin
                        r_face_up  <= '0;
                        r_player   <= ~r_player;
                        r_turn_cnt <= '0;
                        r_state    <= S_PICK1;
                    end else begin
                        r_turn_cnt <= r_turn_cnt + TW'(1);
                        if (w_sel_ok) begin
                            r_face_up <= r_face_up | w_cur_mask;
                            if (r_state == S_PICK1) begin
                                r_pick_a <= r_cursor;
                                r_state  <= S_PICK2;
                            end else begin
                                r_pick_b   <= r_cursor;
                                r_show_cnt <= SW'(SHOW_CYCLES - 1);
                                r_state    <= S_SHOW;
                            end
                        end
                    end
                end
                S_SHOW: begin
                    if (r_show_cnt == '0)
                        r_state <= S_RESOLVE;
                    else
                        r_show_cnt <= r_show_cnt - SW'(1);
                end
                S_RESOLVE: begin
                    r_face_up <= r_face_up & ~w_pair_mask;
                    r_score0  <= w_s0_nxt;
                    r_score1  <= w_s1_nxt;
                    if (w_match)
                        r_matched <= r_matched | w_pair_mask;
                    else
                        r_player <= ~r_player;
                    if (w_done) begin
                        r_game_over <= 1'b1;
                        r_winner    <= (w_s0_nxt > w_s1_nxt) ? 2'd1 :
                                       (w_s1_nxt > w_s0_nxt) ? 2'd2 : 2'd3;
                        r_state     <= S_DONE;
                    end else begin
                        r_turn_cnt <= '0;
                        r_state    <= S_PICK1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign card_sym  = r_card_sym;
    assign cursor    = r_cursor;
    assign face_up   = r_face_up;
    assign matched   = r_matched;
    assign player    = r_player;
    assign score0    = r_score0;
    assign score1    = r_score1;
    assign game_over = r_game_over;
    assign winner    = r_winner;
    assign state     = r_state;
endmodule

// File: tb/tb_card_match_controller.sv
// Scoreboard bench: a game-rules model queues the expected outputs per cycle,
// a monitor pops and compares them after each edge.
module tb_card_match_controller;
  localparam int SC = 4;
  localparam int TC = 20;

  logic        clk = 1'b0;
  logic        rst, start, btn_next, btn_sel;
  logic [47:0] deck_sym;
  logic [47:0] card_sym;
  logic [3:0]  cursor, score0, score1;
  logic [15:0] face_up, matched;
  logic        player, game_over;
  logic [1:0]  winner;
  logic [2:0]  state;

  card_match_controller #(.N_CARDS(16), .SHOW_CYCLES(SC), .TURN_CYCLES(TC)) dut (
    .clk(clk), .rst(rst), .start(start), .btn_next(btn_next), .btn_sel(btn_sel),
    .deck_sym(deck_sym), .card_sym(card_sym), .cursor(cursor), .face_up(face_up),
    .matched(matched), .player(player), .score0(score0), .score1(score1),
    .game_over(game_over), .winner(winner), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [47:0] card_sym;
    logic [3:0]  cursor;
    logic [15:0] face_up;
    logic [15:0] matched;
    logic        player;
    logic [3:0]  s0;
    logic [3:0]  s1;
    logic        go;
    logic [1:0]  winner;
    logic [2:0]  state;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // Game model: phase 0 idle, 1 first pick, 2 second pick, 3 reveal, 4 resolve, 5 over.
  int m_phase, m_cur, m_pl, m_a, m_b, m_show, m_turn;
  int m_sc[2];
  int m_sym[16];
  bit m_face[16], m_mat[16];

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit st, input bit nx, input bit sl);
    int c;
    if (r) begin
      m_phase = 0; m_cur = 0; m_pl = 0; m_a = 0; m_b = 0; m_show = 0; m_turn = 0;
      m_sc[0] = 0; m_sc[1] = 0;
      for (int i = 0; i < 16; i++) begin m_sym[i] = 0; m_face[i] = 0; m_mat[i] = 0; end
    end else begin
      case (m_phase)
        0, 5: if (st) begin
          for (int i = 0; i < 16; i++) begin
            m_sym[i] = int'(deck_sym[3*i +: 3]); m_face[i] = 0; m_mat[i] = 0;
          end
          m_sc[0] = 0; m_sc[1] = 0; m_cur = 0; m_pl = 0; m_turn = 0; m_phase = 1;
        end
        1, 2: begin
          c = m_cur;
          if (nx) m_cur = (m_cur + 1) % 16;
          if (m_turn == TC - 1) begin
            for (int i = 0; i < 16; i++) m_face[i] = 0;
            m_pl = 1 - m_pl; m_turn = 0; m_phase = 1;
          end else begin
            m_turn++;
            if (sl && !m_face[c] && !m_mat[c]) begin
              m_face[c] = 1;
              if (m_phase == 1) begin m_a = c; m_phase = 2; end
              else begin m_b = c; m_show = SC; m_phase = 3; end
            end
          end
        end
        3: begin
          m_show--;
          if (m_show == 0) m_phase = 4;
        end
        4: begin
          m_face[m_a] = 0; m_face[m_b] = 0;
          if (m_sym[m_a] == m_sym[m_b]) begin
            m_mat[m_a] = 1; m_mat[m_b] = 1;
            if (m_sc[m_pl] < 8) m_sc[m_pl]++;
          end else m_pl = 1 - m_pl;
          if (m_sc[0] + m_sc[1] == 8) m_phase = 5;
          else begin m_phase = 1; m_turn = 0; end
        end
        default: m_phase = 0;
      endcase
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e = '0;
    for (int i = 0; i < 16; i++) begin
      e.card_sym[3*i +: 3] = 3'(m_sym[i]);
      e.face_up[i] = m_face[i];
      e.matched[i] = m_mat[i];
    end
    e.cursor = 4'(m_cur);
    e.player = m_pl[0];
    e.s0     = 4'(m_sc[0]);
    e.s1     = 4'(m_sc[1]);
    e.go     = (m_phase == 5);
    e.winner = (m_phase != 5) ? 2'd0 : (m_sc[0] > m_sc[1]) ? 2'd1 : (m_sc[1] > m_sc[0]) ? 2'd2 : 2'd3;
    e.state  = 3'(m_phase);
    return e;
  endfunction

  // One clock: drive inputs, predict post-edge outputs, return mid-cycle.
  task automatic cyc(input bit r, input bit st, input bit nx, input bit sl);
    rst = r; start = st; btn_next = nx; btn_sel = sl;
    model_step(r, st, nx, sl);
    q.push_back(model_out());
    @(posedge clk);
    #2;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("card_sym",  card_sym,  e.card_sym);
        check("cursor",    48'(cursor),    48'(e.cursor));
        check("face_up",   48'(face_up),   48'(e.face_up));
        check("matched",   48'(matched),   48'(e.matched));
        check("player",    48'(player),    48'(e.player));
        check("score0",    48'(score0),    48'(e.s0));
        check("score1",    48'(score1),    48'(e.s1));
        check("game_over", 48'(game_over), 48'(e.go));
        check("winner",    48'(winner),    48'(e.winner));
        check("state",     48'(state),     48'(e.state));
      end
    end
  end

  task automatic goto_card(input int c);
    for (int k = 0; k < 16 && m_cur != c; k++) cyc(0, 0, 1, 0);
  endtask

  task automatic wait_turn_end();
    for (int k = 0; k < 20 && !(m_phase == 1 || m_phase == 5); k++) cyc(0, 0, 0, 0);
    if (!(m_phase == 1 || m_phase == 5)) begin
      total++; bad++;
      $display("FAIL resolve_wait: phase %0d after bound", m_phase);
    end
  endtask

  task automatic pick_pair(input int a, input int b);
    goto_card(a); cyc(0, 0, 0, 1);
    goto_card(b); cyc(0, 0, 0, 1);
    wait_turn_end();
  endtask

  task automatic shuffle_deck();
    int s[16];
    int j, t;
    for (int i = 0; i < 16; i++) s[i] = i / 2;
    for (int i = 15; i > 0; i--) begin
      j = $urandom_range(0, i); t = s[i]; s[i] = s[j]; s[j] = t;
    end
    for (int i = 0; i < 16; i++) deck_sym[3*i +: 3] = 3'(s[i]);
  endtask

  logic [47:0] pair_deck;

  initial begin : stim
    rst = 1'b1; start = 1'b0; btn_next = 1'b0; btn_sel = 1'b0;
    for (int i = 0; i < 16; i++) pair_deck[3*i +: 3] = 3'(i / 2);
    deck_sym = pair_deck;

    cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    check("rst_state", 48'(state), 48'd0);
    check("rst_card_sym", card_sym, 48'd0);
    cyc(0, 1, 0, 0);
    check("start_state", 48'(state), 48'd1);
    check("start_card_sym", card_sym, pair_deck);

    // First pair: cards 0 and 1 match; reveal holds four cycles.
    cyc(0, 0, 0, 1); cyc(0, 0, 1, 0); cyc(0, 0, 0, 1);
    check("show_face", 48'(face_up), 48'h0003);
    for (int k = 0; k < SC - 1; k++) begin
      cyc(0, 0, 0, 0);
      check("show_hold", 48'(state), 48'd3);
    end
    cyc(0, 0, 0, 0);
    check("resolve_state", 48'(state), 48'd4);
    cyc(0, 0, 0, 0);
    check("match_matched", 48'(matched), 48'h0003);
    check("match_score0", 48'(score0), 48'd1);
    check("match_player", 48'(player), 48'd0);

    // Mismatch 2/4 passes the turn.
    pick_pair(2, 4);
    check("mis_face", 48'(face_up), 48'h0);
    check("mis_matched", 48'(matched), 48'h0003);
    check("mis_player", 48'(player), 48'd1);

    // Timeout in PICK2 with a select on the timeout cycle.
    goto_card(6); cyc(0, 0, 0, 1); cyc(0, 0, 1, 0);
    for (int k = 0; k < 40 && m_turn != TC - 1; k++) cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    check("to_state", 48'(state), 48'd1);
    check("to_face", 48'(face_up), 48'h0);
    check("to_player", 48'(player), 48'd0);

    // Same card twice, then re-select a matched card after wrapping the cursor.
    goto_card(8); cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
    check("twice_state", 48'(state), 48'd2);
    check("twice_face", 48'(face_up), 48'h0100);
    goto_card(9); cyc(0, 0, 0, 1); wait_turn_end();
    goto_card(0);
    check("wrap_cursor", 48'(cursor), 48'd0);
    cyc(0, 0, 0, 1);
    check("matched_sel_state", 48'(state), 48'd1);
    check("matched_sel_face", 48'(face_up), 48'h0);

    // Finish the game 5:3.
    pick_pair(2, 3); pick_pair(4, 5); pick_pair(6, 7);
    pick_pair(10, 12);
    pick_pair(10, 11); pick_pair(12, 13); pick_pair(14, 15);
    check("done_state", 48'(state), 48'd5);
    check("done_go", 48'(game_over), 48'd1);
    check("done_winner", 48'(winner), 48'd1);
    check("done_s0", 48'(score0), 48'd5);
    check("done_s1", 48'(score1), 48'd3);

    cyc(0, 1, 0, 0);
    check("restart_state", 48'(state), 48'd1);
    check("restart_s0", 48'(score0), 48'd0);
    check("restart_matched", 48'(matched), 48'd0);

    // Reset during reveal.
    cyc(0, 0, 0, 1); cyc(0, 0, 1, 0); cyc(0, 0, 0, 1); cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    check("midrst_state", 48'(state), 48'd0);
    check("midrst_face", 48'(face_up), 48'd0);
    check("midrst_card_sym", card_sym, 48'd0);

    // Randomized play.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 49) == 0) shuffle_deck();
      cyc($urandom_range(0, 999) < 3, $urandom_range(0, 9) == 0,
          $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 4);
    end
    cyc(0, 0, 0, 0);

    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    #3;
    if (q.size() > 0) begin
      total++; bad++;
      $display("FAIL drain: %0d entries left", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/card_match_controller.md
Name: card_match_controller

Overview:
- Game-sequencing controller for the 4x4 memory-card board: 16 cards, 8 symbol pairs, symbols 3-bit.
- Owns per-card face-up and matched state, the selection cursor, the two-player turn, scores and the reveal/turn timers.
- The VGA renderer reads `face_up`, `matched`, `cursor` and the latched per-card symbols to drive each card's rectangle and symbol select.
- Sits between debounced button pulses and the card-drawing datapath.

Parameters:
- N_CARDS, 16, number of cards. Fixed 16: all port widths below assume it.
- SHOW_CYCLES, 50_000_000, cycles both picked cards stay revealed before resolve (1 s at 50 MHz).
- TURN_CYCLES, 750_000_000, maximum cycles a player may spend in PICK1+PICK2 before forfeiting the turn (15 s).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse: begin a new game; accepted in IDLE and DONE only.
- btn_next  in  1  single-cycle pulse: advance cursor.
- btn_sel  in  1  single-cycle pulse: flip card under cursor.
- deck_sym  in  48  symbol of card i at bits [3i+2:3i]; sampled only on an accepted start.
- card_sym  out  48  latched copy of deck_sym, fed to the renderer's symbol select.
- cursor  out  4  index of highlighted card.
- face_up  out  16  bit i = card i currently revealed and not yet matched.
- matched  out  16  bit i = card i permanently matched.
- player  out  1  player whose turn it is (0/1).
- score0  out  4  pairs found by player 0 (0..8).
- score1  out  4  pairs found by player 1 (0..8).
- game_over  out  1  high while in DONE.
- winner  out  2  valid in DONE: 1 = player 0, 2 = player 1, 3 = tie; 0 otherwise.
- state  out  3  encoded FSM state for debug/LEDs: IDLE=0, PICK1=1, PICK2=2, SHOW=3, RESOLVE=4, DONE=5.

Behaviour:

Reset
- Synchronous and active-high; dominates every other input.
- All outputs 0 and state = IDLE, including card_sym, cursor, face_up, matched, player, scores, game_over, winner.
- Internal picks and timers are cleared.
- Reset mid-game discards all game state.

Start (IDLE or DONE)
- An accepted start latches deck_sym into card_sym.
- It clears face_up, matched, score0, score1, cursor, player, winner and the turn timer.
- Next state: PICK1.
- start is ignored in every other state.

Cursor
- Active in PICK1 and PICK2 only.
- btn_next increments cursor modulo 16 (15 -> 0). No skipping of matched cards.

PICK1
- btn_sel on card c with face_up[c]=0 and matched[c]=0:
  - set face_up[c] on the next edge;
  - store pick_a = c;
  - go to PICK2.
- btn_sel on a face-up or matched card is ignored.

PICK2
- Same selection rule.
- A valid btn_sel stores pick_b, sets face_up[pick_b], loads the show counter and goes to SHOW.
- Selecting pick_a again is ignored, since it is already face-up.

Simultaneous btn_sel and btn_next
- The select applies to the pre-increment cursor.
- The cursor still increments in the same cycle.

Turn timer
- Counts every cycle in PICK1/PICK2.
- Reloads to 0 on entry to PICK1 from RESOLVE, from timeout, or from start.
- Timeout fires on the cycle the timer equals TURN_CYCLES-1. On timeout:
  - clear face_up for every unmatched card;
  - toggle player;
  - go to PICK1.
- Timeout takes priority over btn_sel in the same cycle.

SHOW
- Holds exactly SHOW_CYCLES cycles, then RESOLVE.
- btn_sel and btn_next are ignored.

RESOLVE (one cycle)
- Match (card_sym[pick_a] == card_sym[pick_b]):
  - set matched for both cards and clear their face_up;
  - increment the current player's score;
  - player keeps the turn.
- Mismatch: clear both face_up bits and toggle player.
- Exit to DONE if the updated score0+score1 == 8, otherwise to PICK1.

DONE
- game_over = 1.
- winner is computed from the final scores: the higher score wins; equal scores give 3.

Scores
- Never wrap; the maximum is 8.
- deck_sym validity (each symbol exactly twice) is the caller's responsibility and is not checked.

Test Plan (SHOW_CYCLES=4, TURN_CYCLES=20):
- Reset -> every output 0, state=0. start with deck_sym pairs (0,1),(2,3),…,(14,15) holding symbols 0..7 -> state=1 next cycle, card_sym==deck_sym.
- Select card 0, next, select card 1 -> face_up=0x0003 and state=3 for exactly 4 cycles. RESOLVE then gives matched=0x0003, face_up=0, score0=1, player=0.
- Select cards 2 and 4 (mismatch) -> after SHOW + RESOLVE: face_up=0, matched unchanged, player=1, scores unchanged.
- Select card 6, then idle 20 cycles in PICK2 -> face_up=0, player toggles, state=1. A btn_sel on the timeout cycle is ignored.
- Re-select a matched card, and select the same card twice -> no change to face_up or state. btn_next at cursor=15 -> cursor=0.
- Play all 8 pairs, with player 0 finding 5 and player 1 finding 3 -> state=5, game_over=1, winner=1. start -> fresh game with scores 0. Assert rst mid-SHOW -> all outputs 0 and IDLE next cycle.
